// File: rtl/aes_key_expand_128.sv
// Iterative AES-128 key schedule: one round key every five cycles,
// SubWord done byte-serially through a single combinational sbox.
module aes_key_expand_128 #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic [127:0] round_key,
    output logic         round_key_valid,
    output logic [3:0]   round_idx,
    output logic         done
);

    typedef enum logic [1:0] {IDLE, LOAD, SUB, COMB} state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    k;
    logic [31:0]   temp;
    logic [7:0]    rcon;
    logic [7:0]    sbox_in;
    logic [7:0]    sbox_out;
    logic          load_key;
    logic          sub_step;
    logic          comb_step;
    logic          last_round;
    logic [31:0]   w0, w1, w2, w3;
    logic [31:0]   rot;
    logic [31:0]   t;
    logic [31:0]   w0n, w1n, w2n, w3n;

    assign w0 = round_key[127:96];
    assign w1 = round_key[95:64];
    assign w2 = round_key[63:32];
    assign w3 = round_key[31:0];
    assign rot = {w3[23:0], w3[31:24]};

    always_comb begin
        sbox_in = rot[31:24];
        case (k)
            2'd0: sbox_in = rot[31:24];
            2'd1: sbox_in = rot[23:16];
            2'd2: sbox_in = rot[15:8];
            2'd3: sbox_in = rot[7:0];
            default: sbox_in = rot[31:24];
        endcase
    end

    aes_sbox u_sbox (
        .sbox_in  (sbox_in),
        .sbox_out (sbox_out)
    );

    assign t   = temp ^ {rcon, 24'h000000};
    assign w0n = w0 ^ t;
    assign w1n = w1 ^ w0n;
    assign w2n = w2 ^ w1n;
    assign w3n = w3 ^ w2n;

    assign last_round = (round_idx == 4'(NR - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // The done cycle is already IDLE, but a start seen there is still ignored.
    always_comb begin
        state_nx  = state;
        load_key  = 1'b0;
        sub_step  = 1'b0;
        comb_step = 1'b0;
        unique case (state)
            IDLE: begin
                if (start && !done) begin
                    load_key = 1'b1;
                    state_nx = SUB;
                end
            end
            LOAD: state_nx = SUB;
            SUB: begin
                sub_step = 1'b1;
                if (k == 2'd3) state_nx = COMB;
            end
            COMB: begin
                comb_step = 1'b1;
                state_nx  = last_round ? IDLE : SUB;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            round_key       <= '0;
            round_key_valid <= 1'b0;
            round_idx       <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            k               <= '0;
            temp            <= '0;
            rcon            <= 8'h01;
        end else begin
            round_key_valid <= 1'b0;
            done            <= 1'b0;
            if (done) busy <= 1'b0;
            if (load_key) begin
                round_key       <= key_in;
                round_idx       <= '0;
                rcon            <= 8'h01;
                k               <= '0;
                round_key_valid <= 1'b1;
                busy            <= 1'b1;
            end
            if (sub_step) begin
                case (k)
                    2'd0: temp[31:24] <= sbox_out;
                    2'd1: temp[23:16] <= sbox_out;
                    2'd2: temp[15:8]  <= sbox_out;
                    2'd3: temp[7:0]   <= sbox_out;
                    default: temp[31:24] <= sbox_out;
                endcase
                k <= k + 2'd1;
            end
            if (comb_step) begin
                round_key       <= {w0n, w1n, w2n, w3n};
                round_idx       <= round_idx + 4'd1;
                rcon            <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                round_key_valid <= 1'b1;
                done            <= last_round;
            end
        end
    end

endmodule

// Byte sbox: multiplicative inverse in GF(2^8) as x^254, then the affine map.
module aes_sbox (
    input  logic [7:0] sbox_in,
    output logic [7:0] sbox_out
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    logic [7:0] sq;
    logic [7:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as required.
    always_comb begin
        sq  = sbox_in;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        sbox_out = inv
                 ^ {inv[6:0], inv[7]}
                 ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]}
                 ^ {inv[3:0], inv[7:4]}
                 ^ 8'h63;
    end

endmodule

// File: tb/tb_aes_key_expand_128.sv
// Self-checking bench for aes_key_expand_128 against a word-level
// FIPS-197 key expansion model.
module tb_aes_key_expand_128;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic [127:0] round_key;
    logic         round_key_valid;
    logic [3:0]   round_idx;
    logic         done;

    aes_key_expand_128 #(.NR(10)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .key_in          (key_in),
        .busy            (busy),
        .round_key       (round_key),
        .round_key_valid (round_key_valid),
        .round_idx       (round_idx),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]   sbox_tab [0:255];
    logic [7:0]   rcon_tab [0:9] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                     8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] exp_rk [0:10];

    logic [127:0] got_key [0:10];
    int           got_cyc [0:10];
    int           npulse, order_err, busy_first, busy_last, busy_cnt;
    int           done_cyc, done_bad;

    typedef struct {
        logic [127:0] key;
        logic [127:0] idx1;
        logic [127:0] idx10;
    } vec_t;
    vec_t vecs [0:1];

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, got, exp);
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [14:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (15'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (15'h11b << (i - 8));
        return p[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, c, s;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8]
                     ^ inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ c[i];
            sbox_tab[x] = s;
        end
    endtask

    task automatic model(input logic [127:0] key);
        logic [31:0] w [0:43];
        logic [31:0] tw;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32 * i -: 32];
        for (int i = 4; i < 44; i++) begin
            tw = w[i - 1];
            if (i % 4 == 0) begin
                tw = {tw[23:0], tw[31:24]};
                tw = {sbox_tab[tw[31:24]], sbox_tab[tw[23:16]],
                      sbox_tab[tw[15:8]], sbox_tab[tw[7:0]]};
                tw = tw ^ {rcon_tab[i / 4 - 1], 24'h0};
            end
            w[i] = w[i - 4] ^ tw;
        end
        for (int r = 0; r < 11; r++)
            exp_rk[r] = {w[4 * r], w[4 * r + 1], w[4 * r + 2], w[4 * r + 3]};
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Entered at a negedge; leaves at a negedge with start low.
    task automatic run_exp(input logic [127:0] key, input int inj_cyc,
                           input logic [127:0] inj_key, input int ncyc);
        npulse = 0; order_err = 0; busy_first = -1; busy_last = -1;
        busy_cnt = 0; done_cyc = -1; done_bad = 0;
        for (int r = 0; r < 11; r++) begin
            got_key[r] = '0;
            got_cyc[r] = -1;
        end
        start  = 1'b1;
        key_in = key;
        @(negedge clk);
        for (int c = 1; c <= ncyc; c++) begin
            if (round_key_valid) begin
                if (npulse < 11) begin
                    got_key[npulse] = round_key;
                    got_cyc[npulse] = c;
                    if (round_idx != 4'(npulse)) order_err++;
                end
                npulse++;
            end
            if (busy) begin
                if (busy_first < 0) busy_first = c;
                busy_last = c;
                busy_cnt++;
            end
            if (done) begin
                if (done_cyc < 0) done_cyc = c;
                if (!round_key_valid || round_idx != 4'd10) done_bad++;
            end
            if (c == inj_cyc) begin
                start  = 1'b1;
                key_in = inj_key;
            end else begin
                start  = 1'b0;
                key_in = rnd128();
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string name);
        chk({name, " pulses"}, 128'(npulse), 128'd11);
        chk({name, " idx order"}, 128'(order_err), 128'd0);
        for (int r = 0; r < 11; r++) begin
            chk($sformatf("%s key r%0d", name, r), got_key[r], exp_rk[r]);
            chk($sformatf("%s cyc r%0d", name, r), 128'(got_cyc[r]), 128'(1 + 5 * r));
        end
        chk({name, " busy first"}, 128'(busy_first), 128'd1);
        chk({name, " busy last"}, 128'(busy_last), 128'd51);
        chk({name, " busy cnt"}, 128'(busy_cnt), 128'd51);
        chk({name, " done cyc"}, 128'(done_cyc), 128'd51);
        chk({name, " done align"}, 128'(done_bad), 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k1, k2, fips;
        int cnt, b52, b53, p53_idx, late;
        logic [127:0] p53_key;

        vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
                    128'ha0fafe1788542cb123a339392a6c7605,
                    128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
        vecs[1] = '{128'h0,
                    128'h62636363626363636263636362636363,
                    128'hb4ef5bcb3e92e21123e951cf6f8f188e};
        fips = vecs[0].key;

        build_sbox();

        rst = 1'b1; start = 1'b0; key_in = '0;
        @(negedge clk);
        @(negedge clk);
        chk("reset round_key", round_key, 128'h0);
        chk("reset valid", 128'(round_key_valid), 128'h0);
        chk("reset idx", 128'(round_idx), 128'h0);
        chk("reset busy", 128'(busy), 128'h0);
        chk("reset done", 128'(done), 128'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 2; v++) begin
            model(vecs[v].key);
            chk($sformatf("model v%0d idx1", v), exp_rk[1], vecs[v].idx1);
            chk($sformatf("model v%0d idx10", v), exp_rk[10], vecs[v].idx10);
            run_exp(vecs[v].key, -1, '0, 56);
            chk($sformatf("vec%0d idx0", v), got_key[0], vecs[v].key);
            chk($sformatf("vec%0d idx1", v), got_key[1], vecs[v].idx1);
            chk($sformatf("vec%0d idx10", v), got_key[10], vecs[v].idx10);
            check_run($sformatf("vec%0d", v));
            @(negedge clk);
        end

        model(fips);
        run_exp(fips, 20, 128'hdeadbeef00112233445566778899aabb, 56);
        check_run("ignored start");

        for (int i = 0; i < 3; i++) begin
            k1 = rnd128();
            model(k1);
            run_exp(k1, -1, '0, 56);
            check_run($sformatf("rand%0d", i));
        end

        // Asynchronous reset in the middle of a SUB phase.
        model(fips);
        start = 1'b1; key_in = fips;
        @(negedge clk);
        for (int c = 1; c <= 22; c++) begin
            start = 1'b0;
            key_in = rnd128();
            @(negedge clk);
        end
        chk("pre-rst busy", 128'(busy), 128'h1);
        rst = 1'b1;
        #1;
        chk("async rst round_key", round_key, 128'h0);
        chk("async rst valid", 128'(round_key_valid), 128'h0);
        chk("async rst idx", 128'(round_idx), 128'h0);
        chk("async rst busy", 128'(busy), 128'h0);
        chk("async rst done", 128'(done), 128'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int c = 0; c < 60; c++) begin
            if (round_key_valid || busy || done) cnt++;
            @(negedge clk);
        end
        chk("no activity after rst", 128'(cnt), 128'h0);
        run_exp(fips, -1, '0, 56);
        check_run("after rst");

        // Start held high: back-to-back expansions.
        k1 = rnd128();
        k2 = rnd128();
        model(k1);
        npulse = 0; b52 = -1; b53 = -1; p53_idx = -1; p53_key = '0; late = 0;
        for (int r = 0; r < 11; r++) got_key[r] = '0;
        start = 1'b1; key_in = k1;
        @(negedge clk);
        for (int c = 1; c <= 55; c++) begin
            if (round_key_valid) begin
                if (c <= 51 && npulse < 11) got_key[npulse] = round_key;
                if (c == 53) begin
                    p53_idx = int'(round_idx);
                    p53_key = round_key;
                end else if (c > 51) late++;
                npulse++;
            end
            if (c == 52) b52 = int'(busy);
            if (c == 53) b53 = int'(busy);
            if (c == 10) key_in = k2;
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b pulses", 128'(npulse), 128'd12);
        chk("b2b first idx10", got_key[10], exp_rk[10]);
        chk("b2b busy c52", 128'(b52), 128'd0);
        chk("b2b busy c53", 128'(b53), 128'd1);
        chk("b2b c53 idx", 128'(p53_idx), 128'd0);
        chk("b2b c53 key", p53_key, k2);
        chk("b2b stray pulse", 128'(late), 128'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
